// File: rtl/wb_dsp_slave_regfile.sv
// Wishbone classic single-beat slave exposing ID, interrupt enable/pending and
// per-channel EQ_ADDR / CONTROL / STATUS registers for a bank of DSP engines.
module wb_dsp_slave_regfile #(
    parameter int DW     = 32,
    parameter int AW     = 8,
    parameter int NUM_CH = 4
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst_n,
    input  logic [AW-1:0]        wb_adr_i,
    input  logic [DW-1:0]        wb_dat_i,
    input  logic [3:0]           wb_sel_i,
    input  logic                 wb_we_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic [2:0]           wb_cti_i,
    input  logic [1:0]           wb_bte_i,
    output logic [DW-1:0]        wb_dat_o,
    output logic                 wb_ack_o,
    output logic                 wb_err_o,
    output logic                 wb_rty_o,
    input  logic [NUM_CH*DW-1:0] status_i,
    input  logic [NUM_CH-1:0]    done_i,
    output logic [NUM_CH*DW-1:0] equation_address_o,
    output logic [NUM_CH*DW-1:0] control_o,
    output logic [NUM_CH-1:0]    start_o,
    output logic                 interrupt_o
);

    localparam int PW = AW - 4;
    localparam logic [DW-1:0] ID_VALUE = {16'hD5A0, 8'h02, 8'(NUM_CH)};

    logic              unused_inputs;
    logic              req;
    logic [PW-1:0]     page;
    logic [1:0]        sub;
    logic              glob_page;
    logic              id_hit;
    logic              en_hit;
    logic              pend_hit;
    logic [NUM_CH-1:0] ch_hit;
    logic              addr_valid;
    logic              ro_hit;
    logic              bad_access;
    logic              do_ack;
    logic              do_err;
    logic              wr;
    logic [DW-1:0]     rdata;
    logic [DW-1:0]     en_merged;
    logic [NUM_CH-1:0] irq_en_reg;
    logic [NUM_CH-1:0] irq_pend_reg;
    logic [NUM_CH-1:0] irq_pend_next;
    logic [NUM_CH-1:0] pend_clr;
    logic [NUM_CH-1:0] done_reg;
    logic [NUM_CH-1:0] done_rise;
    logic              armed_reg;

    function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] old_v,
                                                 input logic [DW-1:0] new_v,
                                                 input logic [3:0]    sel);
        logic [DW-1:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return res;
    endfunction

    assign unused_inputs = ^{wb_cti_i, wb_bte_i, wb_adr_i[1:0]};
    assign wb_rty_o      = 1'b0;

    // A response blocks a new request for one cycle, giving every-other-cycle acks.
    assign req  = wb_cyc_i & wb_stb_i & ~(wb_ack_o | wb_err_o);
    assign page = wb_adr_i[AW-1:4];
    assign sub  = wb_adr_i[3:2];

    assign glob_page = (page == '0);
    assign id_hit    = glob_page && (sub == 2'd0);
    assign en_hit    = glob_page && (sub == 2'd1);
    assign pend_hit  = glob_page && (sub == 2'd2);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_hit
            assign ch_hit[gi] = (page == PW'(gi + 1)) && (sub != 2'd3);
        end
    endgenerate

    assign addr_valid = (glob_page && (sub != 2'd3)) || (|ch_hit);
    assign ro_hit     = id_hit || ((|ch_hit) && (sub == 2'd2));
    assign bad_access = ~addr_valid || (wb_we_i && ro_hit);
    assign do_ack     = req & ~bad_access;
    assign do_err     = req & bad_access;
    assign wr         = do_ack & wb_we_i;

    always_comb begin
        rdata = '0;
        if (id_hit)   rdata = ID_VALUE;
        if (en_hit)   rdata[NUM_CH-1:0] = irq_en_reg;
        if (pend_hit) rdata[NUM_CH-1:0] = irq_pend_reg;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_hit[i]) begin
                case (sub)
                    2'd0:    rdata = equation_address_o[i*DW +: DW];
                    2'd1:    rdata = control_o[i*DW +: DW];
                    default: rdata = status_i[i*DW +: DW];
                endcase
            end
        end
    end

    assign en_merged = lane_merge(DW'(irq_en_reg), wb_dat_i, wb_sel_i);
    assign pend_clr  = (wr && pend_hit && wb_sel_i[0]) ? wb_dat_i[NUM_CH-1:0] : '0;
    // armed_reg masks the first sampled edge so a done held through reset is not a rise.
    assign done_rise     = done_i & ~done_reg & {NUM_CH{armed_reg}};
    assign irq_pend_next = (irq_pend_reg & ~pend_clr) | done_rise;

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wb_ack_o     <= 1'b0;
            wb_err_o     <= 1'b0;
            wb_dat_o     <= '0;
            irq_en_reg   <= '0;
            irq_pend_reg <= '0;
            done_reg     <= '0;
            armed_reg    <= 1'b0;
            interrupt_o  <= 1'b0;
        end else begin
            wb_ack_o     <= do_ack;
            wb_err_o     <= do_err;
            if (do_err) begin
                wb_dat_o <= '0;
            end else if (do_ack && !wb_we_i) begin
                wb_dat_o <= rdata;
            end
            if (wr && en_hit) irq_en_reg <= en_merged[NUM_CH-1:0];
            irq_pend_reg <= irq_pend_next;
            done_reg     <= done_i;
            armed_reg    <= 1'b1;
            interrupt_o  <= |(irq_pend_reg & irq_en_reg);
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DW-1:0] eq_reg;
            logic [DW-1:0] ctl_reg;
            logic          start_reg;
            logic [DW-1:0] eq_merged;
            logic [DW-1:0] ctl_merged;
            logic          eq_wr;
            logic          ctl_wr;

            assign eq_wr      = wr && ch_hit[gi] && (sub == 2'd0);
            assign ctl_wr     = wr && ch_hit[gi] && (sub == 2'd1);
            assign eq_merged  = lane_merge(eq_reg, wb_dat_i, wb_sel_i);
            assign ctl_merged = lane_merge(ctl_reg, wb_dat_i, wb_sel_i);

            always_ff @(posedge wb_clk or negedge wb_rst_n) begin
                if (!wb_rst_n) begin
                    eq_reg    <= '0;
                    ctl_reg   <= '0;
                    start_reg <= 1'b0;
                end else begin
                    start_reg <= ctl_wr && wb_sel_i[0] && wb_dat_i[0];
                    if (eq_wr)  eq_reg  <= eq_merged;
                    // START is a pulse, never stored.
                    if (ctl_wr) ctl_reg <= {ctl_merged[DW-1:1], 1'b0};
                end
            end

            assign equation_address_o[gi*DW +: DW] = eq_reg;
            assign control_o[gi*DW +: DW]          = ctl_reg;
            assign start_o[gi]                     = start_reg;
        end
    endgenerate

endmodule

// File: tb/tb_wb_dsp_slave_regfile.sv
// Directed bench for wb_dsp_slave_regfile: bus responses are checked by a
// scoreboard monitor, side-band outputs are checked inline.
module tb_wb_dsp_slave_regfile;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NC = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [AW-1:0]    adr = '0;
    logic [DW-1:0]    dat_w = '0;
    logic [3:0]       sel = '0;
    logic             we = 1'b0;
    logic             cyc = 1'b0;
    logic             stb = 1'b0;
    logic [2:0]       cti = 3'd0;
    logic [1:0]       bte = 2'd0;
    logic [DW-1:0]    dat_r;
    logic             ack;
    logic             err;
    logic             rty;
    logic [NC*DW-1:0] status = {32'h44440004, 32'h33330003, 32'h22220002, 32'h11110001};
    logic [NC-1:0]    done = '0;
    logic [NC*DW-1:0] eq_addr;
    logic [NC*DW-1:0] control;
    logic [NC-1:0]    start;
    logic             intr;

    typedef struct {
        string       name;
        logic        err;
        logic        chk;
        logic [31:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] done_on_strobe = '0;

    wb_dsp_slave_regfile #(.DW(DW), .AW(AW), .NUM_CH(NC)) dut (
        .wb_clk             (clk),
        .wb_rst_n           (rst_n),
        .wb_adr_i           (adr),
        .wb_dat_i           (dat_w),
        .wb_sel_i           (sel),
        .wb_we_i            (we),
        .wb_cyc_i           (cyc),
        .wb_stb_i           (stb),
        .wb_cti_i           (cti),
        .wb_bte_i           (bte),
        .wb_dat_o           (dat_r),
        .wb_ack_o           (ack),
        .wb_err_o           (err),
        .wb_rty_o           (rty),
        .status_i           (status),
        .done_i             (done),
        .equation_address_o (eq_addr),
        .control_o          (control),
        .start_o            (start),
        .interrupt_o        (intr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, expv);
        end else begin
            $display("ok   %s: 0x%08h", name, got);
        end
    endtask

    // Scoreboard monitor: every ack/err pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (ack || err)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got ack=%0b err=%0b expected no response", ack, err);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_resp"}, {30'd0, ack, err}, {30'd0, !e.err, e.err});
                    if (e.chk) check({e.name, "_data"}, dat_r, e.data);
                end
            end
        end
    end

    task automatic wb_xfer(input string name, input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic w, input logic exp_err,
                           input logic [31:0] exp_data);
        exp_t e;
        int   n;
        @(negedge clk);
        adr = a; dat_w = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
        done = done | done_on_strobe;
        e.name = name; e.err = exp_err; e.chk = !w || exp_err;
        e.data = exp_err ? 32'h0 : exp_data;
        exp_q.push_back(e);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(ack || err) && n < 8);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (n >= 8) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no response expected ack/err within 8 cycles", name);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int acks;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack_err", {30'd0, ack, err}, 32'h0);
        check("rst_dat", dat_r, 32'h0);
        check("rst_start_intr_rty", {27'd0, start, intr}, 32'h0);
        check("rst_eq2", eq_addr[95:64], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // ID, sel=0 write, EQ_ADDR lane write
        wb_xfer("id", 8'h00, 32'h0, 4'hF, 1'b0, 1'b0, 32'hD5A00204);
        wb_xfer("eq0_sel0_wr", 8'h10, 32'hFFFFFFFF, 4'h0, 1'b1, 1'b0, 32'h0);
        wb_xfer("eq0_sel0_rd", 8'h10, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0);
        wb_xfer("eq2_wr", 8'h30, 32'hDEADBEEF, 4'b0101, 1'b1, 1'b0, 32'h0);
        wb_xfer("eq2_rd", 8'h30, 32'h0, 4'hF, 1'b0, 1'b0, 32'h00AD00EF);
        check("eq2_port", eq_addr[95:64], 32'h00AD00EF);

        // CONTROL start pulse
        wb_xfer("ctl1_wr", 8'h24, 32'h00000081, 4'hF, 1'b1, 1'b0, 32'h0);
        check("start_pulse", {28'd0, start}, 32'h2);
        @(posedge clk); #1;
        check("start_clear", {28'd0, start}, 32'h0);
        wb_xfer("ctl1_rd", 8'h24, 32'h0, 4'hF, 1'b0, 1'b0, 32'h00000080);
        check("ctl1_port", control[63:32], 32'h00000080);

        // Interrupts
        wb_xfer("irqen_wr", 8'h04, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0, 32'h0);
        wb_xfer("irqen_rd", 8'h04, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0000000F);
        check("intr_idle", {31'd0, intr}, 32'h0);
        @(negedge clk); done = 4'h8;
        idle(2); done = 4'h0;
        idle(2);
        check("intr_set", {31'd0, intr}, 32'h1);
        wb_xfer("pend_rd", 8'h08, 32'h0, 4'hF, 1'b0, 1'b0, 32'h8);
        wb_xfer("pend_clr", 8'h08, 32'h8, 4'h1, 1'b1, 1'b0, 32'h0);
        check("intr_lag", {31'd0, intr}, 32'h1);
        @(posedge clk); #1;
        check("intr_cleared", {31'd0, intr}, 32'h0);
        wb_xfer("pend_rd0", 8'h08, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0);
        idle(2);
        done_on_strobe = 4'h8;
        wb_xfer("pend_clr_race", 8'h08, 32'h8, 4'h1, 1'b1, 1'b0, 32'h0);
        done_on_strobe = 4'h0;
        done = 4'h0;
        wb_xfer("pend_rd_race", 8'h08, 32'h0, 4'hF, 1'b0, 1'b0, 32'h8);
        check("intr_race", {31'd0, intr}, 32'h1);

        // Decode errors and RO writes
        wb_xfer("rd_0c", 8'h0C, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0);
        wb_xfer("rd_50", 8'h50, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0);
        wb_xfer("wr_18", 8'h18, 32'h12345678, 4'hF, 1'b1, 1'b1, 32'h0);
        wb_xfer("wr_3c", 8'h3C, 32'h12345678, 4'hF, 1'b1, 1'b1, 32'h0);
        wb_xfer("wr_id", 8'h00, 32'h12345678, 4'hF, 1'b1, 1'b1, 32'h0);
        wb_xfer("st0_rd", 8'h18, 32'h0, 4'hF, 1'b0, 1'b0, 32'h11110001);
        wb_xfer("st3_rd", 8'h48, 32'h0, 4'hF, 1'b0, 1'b0, 32'h44440004);
        wb_xfer("eq2_rd_after_err", 8'h30, 32'h0, 4'hF, 1'b0, 1'b0, 32'h00AD00EF);

        // Held strobe: response every other cycle
        idle(2);
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e.name = "id_held"; e.err = 1'b0; e.chk = 1'b1; e.data = 32'hD5A00204;
            exp_q.push_back(e);
        end
        adr = 8'h00; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        acks = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        cyc = 1'b0; stb = 1'b0;
        check("held_ack_count", acks, 3);
        idle(2);

        // Reset between strobe and ack edge, done held high through release
        @(negedge clk);
        adr = 8'h30; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        done = 4'h8;
        #2 rst_n = 1'b0;
        #1;
        check("arst_ack_err", {30'd0, ack, err}, 32'h0);
        check("arst_dat", dat_r, 32'h0);
        check("arst_intr_start", {27'd0, start, intr}, 32'h0);
        check("arst_eq2", eq_addr[95:64], 32'h0);
        @(posedge clk); #1;
        check("arst_no_ack", {30'd0, ack, err}, 32'h0);
        cyc = 1'b0; stb = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(4);
        check("post_rst_no_resp", {30'd0, ack, err}, 32'h0);
        wb_xfer("pend_after_rst", 8'h08, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0);
        check("intr_after_rst", {31'd0, intr}, 32'h0);
        done = 4'h0;
        idle(3);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wb_dsp_slave_regfile.md
WB_DSP_SLAVE_REGFILE -- requirements
Module: wb_dsp_slave_regfile

Interface
REQ-001 Parameters (name, default, meaning): DW, 32, data width (fixed 32 in this generation); AW, 8, byte-address width; NUM_CH, 4, DSP channel count (1..8).
REQ-002 Reset: one clock; reset is asynchronous and active-low.
REQ-003 Ports (name, direction, width, meaning), listed clock and reset first:
- wb_clk, in, 1, clock.
- wb_rst_n, in, 1, async active-low reset.
- wb_adr_i, in, AW, byte address.
- wb_dat_i, in, DW, write data.
- wb_sel_i, in, 4, byte lanes.
- wb_we_i, wb_cyc_i, wb_stb_i, in, 1 each, Wishbone controls.
- wb_cti_i, in, 3; wb_bte_i, in, 2; both ignored.
- wb_dat_o, out, DW, read data.
- wb_ack_o, wb_err_o, wb_rty_o, out, 1 each, responses.
- status_i, in, NUM_CH*DW, per-channel status (channel n at bits [n*DW +: DW]).
- done_i, in, NUM_CH, per-channel done level.
- equation_address_o, out, NUM_CH*DW, per-channel equation address.
- control_o, out, NUM_CH*DW, per-channel control.
- start_o, out, NUM_CH, one-cycle start pulses.
- interrupt_o, out, 1, combined interrupt.

Function
REQ-004 Address map, decoded on wb_adr_i with bits [1:0] ignored:
- 0x00 ID, RO: {16'hD5A0, 8'h02, NUM_CH[7:0]}.
- 0x04 IRQ_EN, RW: bits [NUM_CH-1:0]; upper bits read 0.
- 0x08 IRQ_PEND, W1C.
- Channel n base = 0x10 + n*0x10: +0x0 EQ_ADDR RW; +0x4 CONTROL RW; +0x8 STATUS RO (status_i slice); +0xC reserved.
REQ-005 Decode error: any address at 0x0C, at a channel +0xC offset, or at or beyond 0x10+NUM_CH*0x10 SHALL be treated as invalid.
REQ-006 Handshake (classic single-beat): when cyc&stb is high and no response was issued in the previous cycle, the next edge SHALL assert exactly one response for one cycle:
- wb_err_o for an invalid address or a write to a RO register;
- wb_ack_o otherwise.
REQ-007 No response during an idle cycle or during the cycle immediately after a response; back-to-back strobes get a response every second cycle.
REQ-008 wb_rty_o SHALL be constant 0.
REQ-009 Write commit: registers SHALL update on the same edge that wb_ack_o asserts, per byte lane selected by wb_sel_i; unselected lanes hold.
REQ-010 Errored cycles SHALL modify no state.
REQ-011 Read data: wb_dat_o SHALL be registered on the acking edge; on err it SHALL be 0; otherwise it holds its last value.
REQ-012 CONTROL bit 0 (START) is self-clearing and SHALL always read 0.
REQ-013 An acked CONTROL write with wb_sel_i[0]=1 and wb_dat_i[0]=1 SHALL pulse start_o[n] high for exactly the cycle after the ack edge; control_o[n*DW] SHALL stay 0.
REQ-014 Done edge detect: each done_i[n] is registered; a 0->1 transition SHALL set IRQ_PEND[n] on the following edge.
REQ-015 IRQ_PEND clear: an acked write to IRQ_PEND with wb_sel_i[0]=1 SHALL clear each bit whose wb_dat_i bit is 1.
REQ-016 Simultaneous set and W1C clear on the same bit in the same cycle: set SHALL win.
REQ-017 interrupt_o SHALL be registered: interrupt_o <= |(IRQ_PEND & IRQ_EN).
REQ-018 Delay rule: interrupt_o follows a pend or enable change by one cycle.
REQ-019 Writes with wb_sel_i=0 SHALL be acked with no state change.

Reset
REQ-020 While wb_rst_n is low, all of the following SHALL be 0 immediately, independent of wb_clk: registers, done history, start_o, interrupt_o, wb_ack_o, wb_err_o, wb_dat_o.
REQ-021 Reset asserted mid-cycle SHALL abort the transaction with no response.
REQ-022 After release, the first response requires a fresh cyc&stb.
REQ-023 A done_i held high through reset release SHALL NOT set pending.

Verification
REQ-024 Write EQ_ADDR ch2 (0x30) = 0xDEADBEEF, sel=4'b0101, then read it back -> ack each cycle once, read = 0x00AD00EF, equation_address_o[95:64] = 0x00AD00EF.
REQ-025 Write CONTROL ch1 (0x24) = 0x00000081 -> start_o = 4'b0010 for one cycle, read of 0x24 = 0x00000080.
REQ-026 Set IRQ_EN = 0xF, pulse done_i[3] -> IRQ_PEND = 0x8, interrupt_o = 1; write 0x8 to 0x08 -> interrupt_o = 0 two cycles later; repeat the clear in the same cycle as a done_i[3] rise -> pend stays 0x8.
REQ-027 Read 0x0C, read 0x50 (NUM_CH=4), write 0x18 -> wb_err_o one cycle each, wb_ack_o = 0, wb_dat_o = 0, STATUS unchanged.
REQ-028 Read ID -> 0xD5A00204 for NUM_CH=4; cyc&stb held 6 cycles -> exactly 3 ack pulses.
REQ-029 Assert wb_rst_n low between stb and the ack edge -> no ack, all outputs 0 asynchronously; with done_i held high across reset release -> IRQ_PEND stays 0.
